// File: rtl/fft_bin_rx.sv
// Per-bin power (re^2+im^2) stream with bin indexing, frame-end tagging and peak search; 3-cycle latency.
// A single enable stalls every stage together, so s_axis_tready drops when the output beat is held.
module fft_bin_rx #(
  parameter int DATA_W    = 16,
  parameter int LOG2N_MAX = 12
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [3:0]              cfg_log2n,
  input  logic [2*DATA_W-1:0]     s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  output logic [2*DATA_W-1:0]     m_axis_tdata,
  output logic [LOG2N_MAX-1:0]    m_axis_tuser,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic                    peak_valid,
  output logic [LOG2N_MAX-1:0]    peak_bin,
  output logic [2*DATA_W-1:0]     peak_mag,
  output logic                    evt_tlast_missing,
  output logic                    evt_tlast_unexpected
);

  localparam int W2 = 2 * DATA_W;
  localparam int BW = LOG2N_MAX;
  localparam logic [3:0] L_MIN = 4'd3;
  localparam logic [3:0] L_MAX = 4'(LOG2N_MAX);
  localparam logic [BW-1:0] BIN_ONE = {{(BW-1){1'b0}}, 1'b1};

  // Highest bin index of a frame for the requested size, after clamping.
  function automatic logic [BW-1:0] last_bin_of(input logic [3:0] log2n);
    logic [3:0]  l;
    logic [BW:0] one;
    logic [BW:0] n;
    logic [BW:0] nm1;
    if (log2n < L_MIN)      l = L_MIN;
    else if (log2n > L_MAX) l = L_MAX;
    else                    l = log2n;
    one    = '0;
    one[0] = 1'b1;
    n      = one << l;
    nm1    = n - one;
    return nm1[BW-1:0];
  endfunction

  logic            en;
  logic            acc;
  logic [BW-1:0]   bin_cnt;
  logic [BW-1:0]   last_lat;
  logic [BW-1:0]   cur_last;
  logic            is_last;

  assign en            = !m_axis_tvalid | m_axis_tready;
  assign s_axis_tready = en & !areset;
  assign acc           = s_axis_tvalid & s_axis_tready;

  // Frame size is taken from cfg_log2n only when bin 0 is on the input.
  always_comb begin
    cur_last = last_lat;
    if (bin_cnt == '0) cur_last = last_bin_of(cfg_log2n);
    is_last = (bin_cnt == cur_last);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      bin_cnt              <= '0;
      last_lat             <= '0;
      evt_tlast_unexpected <= 1'b0;
      evt_tlast_missing    <= 1'b0;
    end else begin
      evt_tlast_unexpected <= acc & s_axis_tlast & ~is_last;
      evt_tlast_missing    <= acc & ~s_axis_tlast & is_last;
      if (acc) begin
        if (bin_cnt == '0) last_lat <= cur_last;
        bin_cnt <= is_last ? '0 : bin_cnt + BIN_ONE;
      end
    end
  end

  logic                     s1_vld;
  logic signed [DATA_W-1:0] s1_re;
  logic signed [DATA_W-1:0] s1_im;
  logic [BW-1:0]            s1_bin;
  logic                     s1_last;
  logic signed [W2-1:0]     re_x;
  logic signed [W2-1:0]     im_x;
  logic signed [W2-1:0]     sq_re;
  logic signed [W2-1:0]     sq_im;
  logic                     s2_vld;
  logic [W2-1:0]            s2_rr;
  logic [W2-1:0]            s2_ii;
  logic [BW-1:0]            s2_bin;
  logic                     s2_last;
  logic [W2-1:0]            pwr;

  assign re_x  = {{DATA_W{s1_re[DATA_W-1]}}, s1_re};
  assign im_x  = {{DATA_W{s1_im[DATA_W-1]}}, s1_im};
  assign sq_re = re_x * re_x;
  assign sq_im = im_x * im_x;
  // Largest possible sum is 2^(W2-1), so the unsigned add cannot wrap.
  assign pwr   = s2_rr + s2_ii;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      s1_vld        <= 1'b0;
      s1_re         <= '0;
      s1_im         <= '0;
      s1_bin        <= '0;
      s1_last       <= 1'b0;
      s2_vld        <= 1'b0;
      s2_rr         <= '0;
      s2_ii         <= '0;
      s2_bin        <= '0;
      s2_last       <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (en) begin
      s1_vld        <= s_axis_tvalid;
      s1_re         <= s_axis_tdata[DATA_W-1:0];
      s1_im         <= s_axis_tdata[W2-1:DATA_W];
      s1_bin        <= bin_cnt;
      s1_last       <= is_last;
      s2_vld        <= s1_vld;
      s2_rr         <= sq_re;
      s2_ii         <= sq_im;
      s2_bin        <= s1_bin;
      s2_last       <= s1_last;
      m_axis_tvalid <= s2_vld;
      m_axis_tdata  <= pwr;
      m_axis_tuser  <= s2_bin;
      m_axis_tlast  <= s2_vld & s2_last;
    end
  end

  logic            s3_load;
  logic            take_new;
  logic [W2-1:0]   run_mag;
  logic [BW-1:0]   run_bin;
  logic [W2-1:0]   best_mag;
  logic [BW-1:0]   best_bin;

  assign s3_load = en & s2_vld;

  // Strictly-greater compare keeps the lowest bin on ties.
  always_comb begin
    take_new = (s2_bin == '0) || (pwr > run_mag);
    best_mag = run_mag;
    best_bin = run_bin;
    if (take_new) begin
      best_mag = pwr;
      best_bin = s2_bin;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      run_mag    <= '0;
      run_bin    <= '0;
      peak_mag   <= '0;
      peak_bin   <= '0;
      peak_valid <= 1'b0;
    end else begin
      peak_valid <= s3_load & s2_last;
      if (s3_load) begin
        run_mag <= best_mag;
        run_bin <= best_bin;
        if (s2_last) begin
          peak_mag <= best_mag;
          peak_bin <= best_bin;
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_bin_rx.sv
// Randomised scoreboard bench for fft_bin_rx: an input-side model predicts beats, peaks and tlast events.
module tb_fft_bin_rx;
  localparam int DW = 16;
  localparam int LM = 12;

  logic            aclk;
  logic            areset;
  logic [3:0]      cfg_log2n;
  logic [2*DW-1:0] s_axis_tdata;
  logic            s_axis_tvalid;
  logic            s_axis_tready;
  logic            s_axis_tlast;
  logic [2*DW-1:0] m_axis_tdata;
  logic [LM-1:0]   m_axis_tuser;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
  logic            m_axis_tlast;
  logic            peak_valid;
  logic [LM-1:0]   peak_bin;
  logic [2*DW-1:0] peak_mag;
  logic            evt_tlast_missing;
  logic            evt_tlast_unexpected;

  fft_bin_rx #(.DATA_W(DW), .LOG2N_MAX(LM)) dut (
    .aclk(aclk), .areset(areset), .cfg_log2n(cfg_log2n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .peak_valid(peak_valid),
    .peak_bin(peak_bin), .peak_mag(peak_mag),
    .evt_tlast_missing(evt_tlast_missing),
    .evt_tlast_unexpected(evt_tlast_unexpected)
  );

  typedef struct {
    longint dat;
    int     user;
    bit     last;
    longint cyc;
  } beat_t;

  typedef struct {
    int     bin;
    longint mag;
  } pk_t;

  beat_t  exp_q[$];
  pk_t    pk_q[$];
  int     n_chk = 0;
  int     n_fail = 0;
  longint cyc = 0;
  bit     lat_check = 0;
  int     rdy_mode = 0;
  int     m_bin = 0;
  int     m_n = 8;
  longint m_run_mag = 0;
  int     m_run_bin = 0;
  bit     exp_unexp = 0;
  bit     exp_miss = 0;
  int     held_bin = 0;
  longint held_mag = 0;
  bit     pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  always @(posedge aclk) cyc++;

  task automatic check(input string name, input longint act, input longint req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int clamp_l(input int c);
    if (c < 3) return 3;
    if (c > LM) return LM;
    return c;
  endfunction

  // Reference: a frame is simply the next N accepted samples; power is re^2+im^2.
  task automatic model_accept();
    logic signed [DW-1:0] re_s;
    logic signed [DW-1:0] im_s;
    longint pw;
    beat_t  b;
    pk_t    p;
    re_s = s_axis_tdata[DW-1:0];
    im_s = s_axis_tdata[2*DW-1:DW];
    if (m_bin == 0) m_n = 1 << clamp_l(int'(cfg_log2n));
    pw = longint'(re_s) * longint'(re_s) + longint'(im_s) * longint'(im_s);
    b.dat  = pw;
    b.user = m_bin;
    b.last = (m_bin == m_n - 1);
    b.cyc  = cyc;
    exp_q.push_back(b);
    if (m_bin == 0 || pw > m_run_mag) begin
      m_run_mag = pw;
      m_run_bin = m_bin;
    end
    exp_unexp = s_axis_tlast && (m_bin != m_n - 1);
    exp_miss  = !s_axis_tlast && (m_bin == m_n - 1);
    if (m_bin == m_n - 1) begin
      p.bin = m_run_bin;
      p.mag = m_run_mag;
      pk_q.push_back(p);
      m_bin = 0;
    end else begin
      m_bin++;
    end
  endtask

  initial begin
    beat_t b;
    pk_t   p;
    forever begin
      @(negedge aclk);
      if (areset) begin
        check("reset_outputs", longint'(|{s_axis_tready, m_axis_tdata, m_axis_tuser, m_axis_tvalid,
              m_axis_tlast, peak_valid, peak_bin, peak_mag, evt_tlast_missing, evt_tlast_unexpected}), 0);
        exp_q.delete();
        pk_q.delete();
        m_bin = 0;
        exp_unexp = 0;
        exp_miss = 0;
        held_bin = 0;
        held_mag = 0;
      end else begin
        check("s_tready", s_axis_tready, !m_axis_tvalid || m_axis_tready);
        check("evt_unexpected", evt_tlast_unexpected, exp_unexp);
        check("evt_missing", evt_tlast_missing, exp_miss);
        exp_unexp = 0;
        exp_miss = 0;
        if (m_axis_tvalid && m_axis_tready) begin
          n_chk++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_beat: got tuser %0d, expected no beat", m_axis_tuser);
          end else begin
            b = exp_q.pop_front();
            check("beat_data", m_axis_tdata, b.dat);
            check("beat_tuser", m_axis_tuser, b.user);
            check("beat_tlast", m_axis_tlast, b.last);
            if (lat_check) check("latency", cyc - b.cyc, 3);
          end
        end
        if (peak_valid) begin
          check("peak_with_last", m_axis_tvalid & m_axis_tlast, 1);
          n_chk++;
          if (pk_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_peak: got bin %0d, expected no peak_valid", peak_bin);
          end else begin
            p = pk_q.pop_front();
            check("peak_bin", peak_bin, p.bin);
            check("peak_mag", peak_mag, p.mag);
            held_bin = p.bin;
            held_mag = p.mag;
          end
        end else begin
          check("peak_bin_hold", peak_bin, held_bin);
          check("peak_mag_hold", peak_mag, held_mag);
        end
        if (s_axis_tvalid && s_axis_tready) model_accept();
      end
    end
  end

  initial begin
    int pi = 0;
    m_axis_tready = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      case (rdy_mode)
        0: m_axis_tready = 1'b1;
        1: begin m_axis_tready = pat[pi % 6]; pi++; end
        2: m_axis_tready = 1'($urandom_range(0, 1));
        default: m_axis_tready = 1'b0;
      endcase
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic send(input int re, input int im, input bit last, input logic [3:0] cfg);
    bit acc = 0;
    int n = 0;
    s_axis_tdata  = {16'(im), 16'(re)};
    s_axis_tlast  = last;
    cfg_log2n     = cfg;
    s_axis_tvalid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge aclk);
      acc = s_axis_tready;
      @(posedge aclk);
      #1;
      n++;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    if (!acc) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: got no tready in %0d cycles, expected acceptance", n);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20000) begin
      idle(1);
      n++;
    end
    check("drain", exp_q.size(), 0);
    idle(4);
  endtask

  initial begin
    areset = 1'b1;
    cfg_log2n = 4'd3;
    s_axis_tdata = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    idle(3);
    areset = 1'b0;
    idle(2);

    // Ramp frame, full-rate output, latency checked.
    lat_check = 1;
    for (int k = 0; k < 8; k++) send(k, 0, k == 7, 4'd3);
    drain();
    lat_check = 0;

    // Most negative input on both rails.
    send(-32768, -32768, 1'b0, 4'd3);
    for (int k = 1; k < 8; k++) send(k, -k, k == 7, 4'd3);
    drain();

    // Backpressure pattern on the output.
    rdy_mode = 1;
    for (int k = 0; k < 8; k++) send(k, 0, k == 7, 4'd3);
    for (int k = 0; k < 8; k++) send(int'($urandom_range(0, 65535)) - 32768, k * 3, k == 7, 4'd3);
    drain();
    rdy_mode = 0;

    // tlast early at bin 5 and missing at bin 7.
    for (int k = 0; k < 8; k++) send(k + 1, 2, k == 5, 4'd3);
    drain();

    // Flat spectrum: ties keep bin 0.
    for (int k = 0; k < 8; k++) send(10, 0, k == 7, 4'd3);
    drain();

    // Oversized request clamps to the largest frame.
    rdy_mode = 2;
    for (int k = 0; k < 4096; k++)
      send(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768, k == 4095, 4'd15);
    drain();

    // Random sizes changing every beat, random tlast, random gaps.
    for (int k = 0; k < 1500; k++) begin
      send(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 255)) - 128,
           $urandom_range(0, 15) == 0, 4'($urandom_range(0, 9)));
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    drain();

    // Mid-frame reset with output held off.
    rdy_mode = 3;
    idle(2);
    for (int k = 0; k < 3; k++) send(100 + k, 0, 1'b0, 4'd3);
    areset = 1'b1;
    idle(2);
    areset = 1'b0;
    rdy_mode = 0;
    idle(1);
    for (int k = 0; k < 8; k++) send(7 - k, k, k == 7, 4'd3);
    drain();

    check("pending_peaks", pk_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_bin_rx.md
FFT_BIN_RX -- requirements
Module: fft_bin_rx

Interface
REQ-001 The block SHALL have one clock, aclk; reset areset SHALL be asynchronous and active-high.
REQ-002 Parameter DATA_W, default 16, SHALL set the width of each signed input component (re, im).
REQ-003 Parameter LOG2N_MAX, default 12, SHALL set the largest supported frame size, 2^LOG2N_MAX bins.
REQ-004 The ports SHALL be as follows, listed as name, direction, width, meaning:
- aclk  in  1  clock, rising edge.
- areset  in  1  async active-high reset.
- cfg_log2n  in  4  log2 of frame length, sampled at frame start.
- s_axis_tdata  in  2*DATA_W  {im, re}, each signed two's complement, re in the low half.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input beat accepted when high with tvalid.
- s_axis_tlast  in  1  upstream end-of-frame marker, checked only.
- m_axis_tdata  out  2*DATA_W  unsigned re^2+im^2.
- m_axis_tuser  out  LOG2N_MAX  bin index.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last bin of frame.
- peak_valid  out  1  one-cycle pulse, peak result valid.
- peak_bin  out  LOG2N_MAX  bin of maximum power.
- peak_mag  out  2*DATA_W  maximum power.
- evt_tlast_missing  out  1  one-cycle pulse.
- evt_tlast_unexpected  out  1  one-cycle pulse.

Function
REQ-005 Pipeline enable SHALL be en = !m_axis_tvalid | m_axis_tready, and s_axis_tready SHALL equal en (combinational path from m_axis_tready is permitted).
REQ-006 An input beat SHALL be accepted when s_axis_tvalid & s_axis_tready are both high; all pipeline stages SHALL advance only when en is high.
REQ-007 The pipeline SHALL have three register stages: S1 registers re, im, bin index and generated last; S2 registers re*re and im*im; S3 registers the sum into the output.
REQ-008 With en continuously high, m_axis_tvalid for an accepted beat SHALL assert 3 cycles after acceptance; when stalled, no beat SHALL be lost or duplicated.
REQ-009 Each square SHALL be computed at 2*DATA_W bits and the sum SHALL be unsigned at 2*DATA_W bits without saturation. The maximum sum is 2^(2*DATA_W-1) and fits.
REQ-010 Frame length N SHALL equal 2^L, where L is cfg_log2n clamped to the range [3, LOG2N_MAX]. N SHALL be latched on acceptance of the beat at bin 0, and changes to cfg_log2n mid-frame SHALL be ignored.
REQ-011 The bin counter SHALL increment on each accepted beat and wrap to 0 after bin N-1; frame boundaries SHALL be determined by count only, never by s_axis_tlast.
REQ-012 m_axis_tlast SHALL be high exactly on the output beat whose m_axis_tuser equals N-1.
REQ-013 evt_tlast_unexpected SHALL pulse the cycle after accepting a beat with s_axis_tlast=1 at a bin other than N-1.
REQ-014 evt_tlast_missing SHALL pulse the cycle after accepting bin N-1 with s_axis_tlast=0.
REQ-015 Neither tlast error SHALL alter the counter or the data path.
REQ-016 Peak tracking SHALL update when S3 loads a beat. Bin 0 SHALL initialise the running maximum; later bins SHALL replace it only on strictly greater power, so ties keep the lowest bin.
REQ-017 peak_valid SHALL pulse one cycle after S3 loads bin N-1; peak_bin and peak_mag SHALL hold their values until the next peak_valid.

Reset
REQ-018 While areset is high, all outputs SHALL be 0, all stages SHALL be invalid, the bin counter SHALL be 0, and the peak registers SHALL be cleared.
REQ-019 A reset mid-frame SHALL discard the partial frame, and the first beat after reset release SHALL be bin 0.

Verification
REQ-020 cfg_log2n=3; 8 beats with re=k, im=0 (k=0..7), tlast on the 8th, m_axis_tready=1 -> m_axis_tdata sequence 0,1,4,...,49; tuser 0..7; tlast on bin 7; latency 3 cycles; peak_bin=7, peak_mag=49.
REQ-021 DATA_W=16; one beat with re=im=-32768 -> m_axis_tdata=0x80000000.
REQ-022 cfg_log2n=3; m_axis_tready pattern 1,0,0,1,0,1... -> s_axis_tready low whenever m_axis_tvalid & !m_axis_tready; output identical to REQ-020 ordering with no gaps in tuser.
REQ-023 cfg_log2n=3; s_axis_tlast at bin 5 and none at bin 7 -> evt_tlast_unexpected pulse after bin 5; evt_tlast_missing pulse after bin 7; m_axis_tlast still on bin 7.
REQ-024 cfg_log2n=3; all bins re=10, im=0 -> peak_mag=100, peak_bin=0. Separately, cfg_log2n=15 -> frame length 4096 with tlast on tuser 4095.
REQ-025 Assert areset after 3 accepted beats, then drive a full 8-beat frame -> no output from the partial frame; outputs tuser 0..7; one peak_valid.
